// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//
// Time-multiplexed scanner for an 8-digit seven-segment display. A 32-bit
// hex value and an 8-bit digit-enable mask are double-buffered: `load`
// captures them into a pending buffer, and the pending buffer is copied into
// the active buffer only at a frame boundary. The active buffer therefore
// never changes while a frame is being scanned.
//
// Each enabled digit is lit for ON_CYCLES clocks and then blanked for
// BLANK_CYCLES clocks. Blanking removes ghosting while the anode decoder
// switches between digits.
//
// Parameters
//   ON_CYCLES     clocks each digit is lit (>= 1)
//   BLANK_CYCLES  clocks of blanking after each digit (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data[31:0]   eight hex nibbles, digit i = data[4i+3:4i]
//   en[7:0]      digit-enable mask, bit i enables digit i
//   load         one-cycle strobe, samples data/en into the pending buffer
//   sel[2:0]     current digit index, drives the 3-8 anode decoder
//   seg[6:0]     active-high segments {g,f,e,d,c,b,a}
//   valid        high only while the current digit is lit
//   frame_start  one-cycle pulse on the first lit cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  en,
  input  logic        load,
  output logic [2:0]  sel,
  output logic [6:0]  seg,
  output logic        valid,
  output logic        frame_start
);

  // The counter only has to reach the larger of the two phase lengths minus
  // one, so clog2 of that length is enough (at least one bit).
  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ON    = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]      pend_data;
  logic [7:0]       pend_en;
  logic             pend_flag;
  logic [31:0]      act_data;
  logic [7:0]       act_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Index of the lowest set bit; returns 0 for an empty mask (callers only
  // use the result when the mask is known to be non-zero).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Hex digit to segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // -------------------------------------------------------------------------
  // Next-digit and frame-boundary logic
  // -------------------------------------------------------------------------

  // Enabled digits strictly above the current index.
  logic [7:0] above_mask;
  always_comb begin
    above_mask = 8'd0;
    for (int i = 0; i < 8; i++) begin
      above_mask[i] = act_en[i] && (3'(i) > sel);
    end
  end

  logic end_on;
  logic end_blank;
  logic fb;
  logic [7:0]  fb_mask;
  logic [31:0] fb_data;

  assign end_on    = (state == S_ON)    && (cnt == ON_LAST);
  assign end_blank = (state == S_BLANK) && (cnt == BLANK_LAST);

  // A frame boundary is every IDLE edge, or the end of a blank with no
  // higher enabled digit left in this frame.
  assign fb = (state == S_IDLE) || (end_blank && (above_mask == 8'd0));

  // Mask/data that will be active after the boundary: the pending buffer
  // wins only if it held something before this edge. A load on the same
  // edge is not seen here; it is picked up at the following boundary.
  assign fb_mask = pend_flag ? pend_en   : act_en;
  assign fb_data = pend_flag ? pend_data : act_data;

  // -------------------------------------------------------------------------
  // Pending buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= 32'd0;
      pend_en   <= 8'd0;
      pend_flag <= 1'b0;
    end else begin
      if (load) begin
        // A load coinciding with a boundary keeps the flag set so the new
        // sample is applied at the next boundary.
        pend_data <= data;
        pend_en   <= en;
        pend_flag <= 1'b1;
      end else if (fb && pend_flag) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Active buffer: only updated at a frame boundary
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data <= 32'd0;
      act_en   <= 8'd0;
    end else if (fb && pend_flag) begin
      act_data <= fb_data;
      act_en   <= fb_mask;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM, phase counter, digit index and frame pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sel         <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (fb) begin
        cnt <= '0;
        if (fb_mask != 8'd0) begin
          state       <= S_ON;
          sel         <= lowest_bit(fb_mask);
          frame_start <= 1'b1;
        end else begin
          state <= S_IDLE;
          sel   <= 3'd0;
        end
      end else begin
        case (state)
          S_ON: begin
            if (end_on) begin
              state <= S_BLANK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_BLANK: begin
            // A blank ending without a higher digit is handled by fb above.
            if (end_blank) begin
              state <= S_ON;
              sel   <= lowest_bit(above_mask);
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            // Unreachable encoding: fall back to a clean idle.
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= 3'd0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state so they clear with reset
  // -------------------------------------------------------------------------
  logic [3:0] nibble;
  assign nibble = act_data[{sel, 2'b00} +: 4];
  assign valid  = (state == S_ON);
  assign seg    = valid ? hex7(nibble) : 7'd0;

endmodule
